vsbox_sequencer: RTL and testbench

- Multi-cycle controller for the vector S-box special instruction (opcode 5'b11110).
- Sits beside the decode/execute stage. On a decoded S-box op it stalls the pipeline and walks the 16 lanes of the source vector register through the single shared S-box ROM, one byte per cycle.
- Collects the substituted bytes and issues a single vector register write.
- Replaces the single-cycle MemToReg=2'b10 path, so one ROM instance serves all lanes.

---
 rtl/vsbox_sequencer_if.sv | 31 +++
 rtl/vsbox_sequencer.sv | 123 ++++++++++++
 tb/tb_vsbox_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vsbox_sequencer_if.sv
// Decode-side and S-box ROM signals of the vector S-box sequencer.
// master = sequencer, slave = pipeline/ROM side.
interface vsbox_sequencer_if #(
    parameter int unsigned VLEN_BYTES = 16,
    parameter int unsigned VREG_AW    = 4
);
    logic                      start;
    logic [0:4]                opcode;
    logic [8*VLEN_BYTES-1:0]   vsrc;
    logic [VREG_AW-1:0]        vrd;
    logic                      flush;
    logic                      rom_en;
    logic [7:0]                rom_addr;
    logic [7:0]                rom_data;
    logic                      stall;
    logic                      busy;
    logic                      vwe;
    logic [VREG_AW-1:0]        vwa;
    logic [8*VLEN_BYTES-1:0]   vresult;
    logic                      done;

    modport master (
        input  start, opcode, vsrc, vrd, flush, rom_data,
        output rom_en, rom_addr, stall, busy, vwe, vwa, vresult, done
    );

    modport slave (
        output start, opcode, vsrc, vrd, flush, rom_data,
        input  rom_en, rom_addr, stall, busy, vwe, vwa, vresult, done
    );
endinterface

// File: rtl/vsbox_sequencer.sv
// Multi-cycle vector S-box controller: walks the source lanes through one shared
// S-box ROM, one byte per cycle, then issues a single vector register write.
module vsbox_sequencer #(
    parameter int unsigned VLEN_BYTES = 16,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned VREG_AW    = 4,
    parameter logic [4:0]  OPC_SBOX   = 5'b11110
) (
    input logic clk,
    input logic rst_n,
    vsbox_sequencer_if.master bus
);
    localparam int unsigned CW = $clog2(VLEN_BYTES) + 1;
    localparam int unsigned VW = 8 * VLEN_BYTES;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StWrite} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       issue_idx_q, issue_idx_d;
    logic [CW-1:0]       cap_idx_q, cap_idx_d;
    logic [VW-1:0]       vsrc_q, vsrc_d;
    logic [VW-1:0]       vresult_q, vresult_d;
    logic [VREG_AW-1:0]  vrd_q, vrd_d;
    logic [ROM_LAT-1:0]  valid_q, valid_d;
    logic [ROM_LAT:0]    valid_shift;

    logic       accept, capture, last_issue, last_cap;
    logic       rom_en, stall, vwe;
    logic [7:0] rom_addr;

    assign accept     = (state_q == StIdle) && bus.start && (bus.opcode == OPC_SBOX) &&
                        !bus.flush;
    // Top of the valid pipe marks a ROM return for the next lane in order.
    assign capture    = valid_q[ROM_LAT-1] && !bus.flush &&
                        ((state_q == StIssue) || (state_q == StDrain));
    assign last_issue = (issue_idx_q == CW'(VLEN_BYTES - 1));
    assign last_cap   = (cap_idx_q == CW'(VLEN_BYTES - 1));

    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        cap_idx_d   = cap_idx_q;
        vsrc_d      = vsrc_q;
        vrd_d       = vrd_q;
        vresult_d   = vresult_q;
        rom_en      = 1'b0;
        rom_addr    = 8'h00;
        stall       = 1'b0;
        vwe         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    vsrc_d      = bus.vsrc;
                    vrd_d       = bus.vrd;
                    issue_idx_d = '0;
                    cap_idx_d   = '0;
                    stall       = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                rom_en = 1'b1;
                stall  = 1'b1;
                for (int i = 0; i < int'(VLEN_BYTES); i++) begin
                    if (issue_idx_q == CW'(i)) rom_addr = vsrc_q[8*i +: 8];
                end
                issue_idx_d = issue_idx_q + 1'b1;
                if (last_issue) state_d = StDrain;
            end
            StDrain: begin
                stall = 1'b1;
                if (capture && last_cap) state_d = StWrite;
            end
            StWrite: begin
                vwe     = !bus.flush;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            for (int i = 0; i < int'(VLEN_BYTES); i++) begin
                if (cap_idx_q == CW'(i)) vresult_d[8*i +: 8] = bus.rom_data;
            end
            cap_idx_d = cap_idx_q + 1'b1;
        end

        if (bus.flush && (state_q != StIdle)) state_d = StIdle;

        valid_shift = {valid_q, rom_en};
        valid_d     = bus.flush ? '0 : valid_shift[ROM_LAT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            issue_idx_q <= '0;
            cap_idx_q   <= '0;
            vsrc_q      <= '0;
            vrd_q       <= '0;
            vresult_q   <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            issue_idx_q <= issue_idx_d;
            cap_idx_q   <= cap_idx_d;
            vsrc_q      <= vsrc_d;
            vrd_q       <= vrd_d;
            vresult_q   <= vresult_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.rom_en   = rom_en;
    assign bus.rom_addr = rom_addr;
    assign bus.stall    = stall;
    assign bus.busy     = (state_q != StIdle);
    assign bus.vwe      = vwe;
    assign bus.done     = vwe;
    assign bus.vwa      = vrd_q;
    assign bus.vresult  = vresult_q;
endmodule

// File: tb/tb_vsbox_sequencer.sv
// Directed bench: one sequencer with a 1-cycle S-box ROM and one with a 3-cycle ROM.
module tb_vsbox_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    vsbox_sequencer_if #(.VLEN_BYTES(16), .VREG_AW(4)) bus1 ();
    vsbox_sequencer_if #(.VLEN_BYTES(16), .VREG_AW(4)) bus3 ();

    vsbox_sequencer #(.ROM_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    vsbox_sequencer #(.ROM_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // AES S-box rows 0x0_, 0x1_ and 0x5_ (the only addresses the vectors use).
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [127:0] r;
        case (a[7:4])
            4'h0:    r = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1:    r = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h5:    r = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            default: r = {16{a ^ 8'h5a}};
        endcase
        return r[8*(15 - int'(a[3:0])) +: 8];
    endfunction

    function automatic logic [127:0] lanes_from(input logic [7:0] base);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(base + 8'(i));
        return v;
    endfunction

    function automatic logic [127:0] sbox_vec(input logic [7:0] base);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = sbox(8'(base + 8'(i)));
        return v;
    endfunction

    logic [7:0] rom1_q;
    logic [7:0] rom3_q [3];
    always @(posedge clk) begin
        if (bus1.rom_en) rom1_q <= sbox(bus1.rom_addr);
        rom3_q[0] <= sbox(bus3.rom_addr);
        rom3_q[1] <= rom3_q[0];
        rom3_q[2] <= rom3_q[1];
    end
    assign bus1.rom_data = rom1_q;
    assign bus3.rom_data = rom3_q[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_total++;
        if ({bus1.rom_en, bus1.rom_addr, bus1.stall, bus1.busy, bus1.vwe, bus1.done,
             bus1.vwa, bus1.vresult} !== '0)
            $display("FAIL reset_u1 got en=%0b addr=%h stall=%0b busy=%0b vwe=%0b want all 0",
                     bus1.rom_en, bus1.rom_addr, bus1.stall, bus1.busy, bus1.vwe);
        else n_pass++;
        n_total++;
        if ({bus3.rom_en, bus3.stall, bus3.busy, bus3.vwe, bus3.done, bus3.vwa,
             bus3.vresult} !== '0)
            $display("FAIL reset_u3 got stall=%0b busy=%0b vwe=%0b want all 0",
                     bus3.stall, bus3.busy, bus3.vwe);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [127:0] exp_v;
        exp_v = sbox_vec(8'h00);
        bus1.vsrc = lanes_from(8'h00); bus1.vrd = 4'd5; bus1.opcode = 5'b11110;
        bus1.start = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            if (c == 1) bus1.start = 1'b0;
            #2;
            n_total++;
            if (bus1.stall !== (c <= 17))
                $display("FAIL basic_stall c=%0d got %0b want %0b", c, bus1.stall, c <= 17);
            else n_pass++;
            n_total++;
            if (bus1.rom_en !== (c >= 1 && c <= 16))
                $display("FAIL basic_rom_en c=%0d got %0b want %0b", c, bus1.rom_en,
                         c >= 1 && c <= 16);
            else n_pass++;
            if (c >= 1 && c <= 16) begin
                n_total++;
                if (bus1.rom_addr !== 8'(c - 1))
                    $display("FAIL basic_rom_addr c=%0d got %h want %h", c, bus1.rom_addr,
                             8'(c - 1));
                else n_pass++;
            end
            n_total++;
            if ({bus1.vwe, bus1.done} !== {2{c == 18}})
                $display("FAIL basic_vwe_done c=%0d got %b want %b", c, {bus1.vwe, bus1.done},
                         {2{c == 18}});
            else n_pass++;
            n_total++;
            if (bus1.busy !== (c >= 1 && c <= 18))
                $display("FAIL basic_busy c=%0d got %0b want %0b", c, bus1.busy,
                         c >= 1 && c <= 18);
            else n_pass++;
            if (c == 18) begin
                n_total++;
                if (bus1.vwa !== 4'd5) $display("FAIL basic_vwa got %0d want 5", bus1.vwa);
                else n_pass++;
                n_total++;
                if (bus1.vresult !== exp_v)
                    $display("FAIL basic_vresult got %h want %h", bus1.vresult, exp_v);
                else n_pass++;
                n_total++;
                if ({bus1.vresult[7:0], bus1.vresult[15:8], bus1.vresult[127:120]} !==
                    24'h637c76)
                    $display("FAIL basic_lanes_0_1_15 got %h %h %h want 63 7c 76",
                             bus1.vresult[7:0], bus1.vresult[15:8], bus1.vresult[127:120]);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_opcode_filter();
        logic [127:0] exp_v;
        exp_v = sbox_vec(8'h10);
        bus1.vsrc = lanes_from(8'h50); bus1.vrd = 4'd1; bus1.opcode = 5'b11100;
        bus1.start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            n_total++;
            if ({bus1.stall, bus1.rom_en, bus1.busy} !== 3'b000)
                $display("FAIL filter_ignored c=%0d got stall/en/busy=%b want 000", c,
                         {bus1.stall, bus1.rom_en, bus1.busy});
            else n_pass++;
            step();
        end
        bus1.vsrc = lanes_from(8'h10); bus1.vrd = 4'd7; bus1.opcode = 5'b11110;
        for (int c = 0; c <= 19; c++) begin
            if (c == 1) bus1.start = 1'b0;
            #2;
            n_total++;
            if (bus1.stall !== (c <= 17))
                $display("FAIL filter_stall c=%0d got %0b want %0b", c, bus1.stall, c <= 17);
            else n_pass++;
            n_total++;
            if (bus1.vwe !== (c == 18))
                $display("FAIL filter_vwe c=%0d got %0b want %0b", c, bus1.vwe, c == 18);
            else n_pass++;
            if (c == 18) begin
                n_total++;
                if ({bus1.vwa, bus1.vresult} !== {4'd7, exp_v})
                    $display("FAIL filter_result got %0d/%h want 7/%h", bus1.vwa, bus1.vresult,
                             exp_v);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_long_latency();
        int en_cnt = 0;
        int vwe_cnt = 0;
        bus3.vsrc = {16{8'h53}}; bus3.vrd = 4'd2; bus3.opcode = 5'b11110;
        bus3.start = 1'b1;
        for (int c = 0; c <= 23; c++) begin
            if (c == 1) bus3.start = 1'b0;
            #2;
            if (bus3.rom_en) en_cnt++;
            if (bus3.vwe) vwe_cnt++;
            n_total++;
            if (bus3.vwe !== (c == 20))
                $display("FAIL lat3_vwe c=%0d got %0b want %0b", c, bus3.vwe, c == 20);
            else n_pass++;
            n_total++;
            if (bus3.stall !== (c <= 19))
                $display("FAIL lat3_stall c=%0d got %0b want %0b", c, bus3.stall, c <= 19);
            else n_pass++;
            if (c == 20) begin
                n_total++;
                if ({bus3.vwa, bus3.vresult} !== {4'd2, {16{8'hed}}})
                    $display("FAIL lat3_result got %0d/%h want 2/all ed", bus3.vwa,
                             bus3.vresult);
                else n_pass++;
            end
            step();
        end
        n_total++;
        if (en_cnt != 16) $display("FAIL lat3_rom_en_count got %0d want 16", en_cnt);
        else n_pass++;
        n_total++;
        if (vwe_cnt != 1) $display("FAIL lat3_vwe_count got %0d want 1", vwe_cnt);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [127:0] exp_v;
        exp_v = sbox_vec(8'h50);
        bus1.vsrc = lanes_from(8'h10); bus1.vrd = 4'd3; bus1.opcode = 5'b11110;
        bus1.start = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            if (c == 1) bus1.start = 1'b0;
            bus1.flush = (c == 8);
            #2;
            if (c == 9) begin
                n_total++;
                if ({bus1.busy, bus1.stall, bus1.rom_en} !== 3'b000)
                    $display("FAIL flush_idle got busy/stall/en=%b want 000",
                             {bus1.busy, bus1.stall, bus1.rom_en});
                else n_pass++;
            end
            n_total++;
            if (bus1.vwe !== 1'b0) $display("FAIL flush_no_vwe c=%0d got 1 want 0", c);
            else n_pass++;
            step();
        end
        bus1.vsrc = lanes_from(8'h50); bus1.vrd = 4'd9; bus1.start = 1'b1;
        for (int c = 0; c <= 19; c++) begin
            if (c == 1) bus1.start = 1'b0;
            #2;
            n_total++;
            if (bus1.vwe !== (c == 18))
                $display("FAIL flush_rerun_vwe c=%0d got %0b want %0b", c, bus1.vwe, c == 18);
            else n_pass++;
            if (c == 18) begin
                n_total++;
                if ({bus1.vwa, bus1.vresult} !== {4'd9, exp_v})
                    $display("FAIL flush_rerun_result got %0d/%h want 9/%h", bus1.vwa,
                             bus1.vresult, exp_v);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        bus1.vsrc = lanes_from(8'h00); bus1.vrd = 4'd4; bus1.opcode = 5'b11110;
        bus1.start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) bus1.start = 1'b0;
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus1.rom_en, bus1.rom_addr, bus1.stall, bus1.busy, bus1.vwe, bus1.done,
             bus1.vwa, bus1.vresult} !== '0)
            $display("FAIL reset_mid got en=%0b addr=%h stall=%0b busy=%0b vwa=%0d want all 0",
                     bus1.rom_en, bus1.rom_addr, bus1.stall, bus1.busy, bus1.vwa);
        else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            #2;
            n_total++;
            if ({bus1.vwe, bus1.busy} !== 2'b00)
                $display("FAIL reset_mid_after c=%0d got vwe/busy=%b want 00", c,
                         {bus1.vwe, bus1.busy});
            else n_pass++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        int cnt = 0;
        logic [127:0] exp_v;
        exp_v = sbox_vec(8'h00);
        bus1.vsrc = lanes_from(8'h00); bus1.vrd = 4'd6; bus1.opcode = 5'b11110;
        for (int c = 0; c <= 40; c++) begin
            bus1.start = (c < 38);
            #2;
            if (bus1.vwe) begin
                cnt++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (c == 18 || c == 19) begin
                n_total++;
                if (bus1.stall !== (c == 19))
                    $display("FAIL b2b_stall c=%0d got %0b want %0b", c, bus1.stall, c == 19);
                else n_pass++;
            end
            if (c == 37) begin
                n_total++;
                if ({bus1.vwa, bus1.vresult} !== {4'd6, exp_v})
                    $display("FAIL b2b_result got %0d/%h want 6/%h", bus1.vwa, bus1.vresult,
                             exp_v);
                else n_pass++;
            end
            step();
        end
        n_total++;
        if (first != 18) $display("FAIL b2b_first_vwe got %0d want 18", first);
        else n_pass++;
        n_total++;
        if (second - first != 19)
            $display("FAIL b2b_vwe_spacing got %0d want 19", second - first);
        else n_pass++;
        n_total++;
        if (cnt != 2) $display("FAIL b2b_vwe_count got %0d want 2", cnt);
        else n_pass++;
    endtask

    initial begin
        bus1.start = 1'b0; bus1.opcode = '0; bus1.vsrc = '0; bus1.vrd = '0; bus1.flush = 1'b0;
        bus3.start = 1'b0; bus3.opcode = '0; bus3.vsrc = '0; bus3.vrd = '0; bus3.flush = 1'b0;
        rst_n = 1'b0;
        step();
        test_reset();
        test_basic();
        test_opcode_filter();
        test_long_latency();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
